// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller with a 32x32 register file and an internal 32-bit ALU.
// Optional immediate operand B is enabled by defining ALU_IMM_EN.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [3:0]  alu_op,
    input  logic        ext_we,
    input  logic [4:0]  ext_waddr,
    input  logic [31:0] ext_wdata,
`ifdef ALU_IMM_EN
    input  logic        use_imm,
    input  logic [31:0] imm,
`endif
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        ext_wr_s;
    logic        wb_wr_s;

    logic [31:0] rf_r [0:31];
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;
    logic [4:0]  rd_r;
    logic [3:0]  op_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [31:0] result_r;
    logic [3:0]  flags_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
`ifdef ALU_IMM_EN
    logic        use_imm_r;
    logic [31:0] imm_r;
`endif

    logic [31:0] alu_f_s;
    logic [32:0] alu_sum_s;
    logic        alu_cf_s;
    logic        alu_of_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        ext_wr_s = 1'b0;
        wb_wr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ext_wr_s = ext_we && (ext_waddr != 5'd0);
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_READ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_READ: state_s = ST_EXEC;
            ST_EXEC: state_s = ST_WB;
            ST_WB: begin
                wb_wr_s = (rd_r != 5'd0);
                state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Registered handshake/status outputs, aligned with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_WB);
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (ext_wr_s) begin
            rf_r[ext_waddr] <= ext_wdata;
        end else if (wb_wr_s) begin
            rf_r[rd_r] <= result_r;
        end else begin
            rf_r[0] <= 32'd0;
        end
    end

    // Request fields latched at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_r <= 5'd0;
            rs2_r <= 5'd0;
            rd_r  <= 5'd0;
            op_r  <= 4'd0;
`ifdef ALU_IMM_EN
            use_imm_r <= 1'b0;
            imm_r     <= 32'd0;
`endif
        end else if (accept_s) begin
            rs1_r <= rs1_addr;
            rs2_r <= rs2_addr;
            rd_r  <= rd_addr;
            op_r  <= alu_op;
`ifdef ALU_IMM_EN
            use_imm_r <= use_imm;
            imm_r     <= imm;
`endif
        end else begin
            op_r <= op_r;
        end
    end

    // Operand fetch in READ; an IDLE-cycle external write has already landed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r <= 32'd0;
            op_b_r <= 32'd0;
        end else if (state_r == ST_READ) begin
            op_a_r <= rf_r[rs1_r];
`ifdef ALU_IMM_EN
            op_b_r <= use_imm_r ? imm_r : rf_r[rs2_r];
`else
            op_b_r <= rf_r[rs2_r];
`endif
        end else begin
            op_a_r <= op_a_r;
        end
    end

    // ALU: op code is {funct7[5], funct3}; CF is carry for add, borrow for sub
    always_comb begin
        alu_f_s   = 32'd0;
        alu_sum_s = 33'd0;
        alu_cf_s  = 1'b0;
        alu_of_s  = 1'b0;
        case (op_r)
            4'b0000: begin
                alu_sum_s = {1'b0, op_a_r} + {1'b0, op_b_r};
                alu_f_s   = alu_sum_s[31:0];
                alu_cf_s  = alu_sum_s[32];
                alu_of_s  = (op_a_r[31] == op_b_r[31]) && (alu_sum_s[31] != op_a_r[31]);
            end
            4'b1000: begin
                alu_sum_s = {1'b0, op_a_r} - {1'b0, op_b_r};
                alu_f_s   = alu_sum_s[31:0];
                alu_cf_s  = alu_sum_s[32];
                alu_of_s  = (op_a_r[31] != op_b_r[31]) && (alu_sum_s[31] != op_a_r[31]);
            end
            4'b0001: alu_f_s = op_a_r << op_b_r;
            4'b0010: alu_f_s = {31'd0, ($signed(op_a_r) < $signed(op_b_r))};
            4'b0011: alu_f_s = {31'd0, (op_a_r < op_b_r)};
            4'b0100: alu_f_s = op_a_r ^ op_b_r;
            4'b0101: alu_f_s = op_a_r >> op_b_r;
            4'b1101: alu_f_s = $unsigned($signed(op_a_r) >>> op_b_r);
            4'b0110: alu_f_s = op_a_r | op_b_r;
            4'b0111: alu_f_s = op_a_r & op_b_r;
            default: alu_f_s = 32'd0;
        endcase
    end

    // Result and flags capture at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= 32'd0;
            flags_r  <= 4'b0000;
        end else if (state_r == ST_EXEC) begin
            result_r <= alu_f_s;
            flags_r  <= {(alu_f_s == 32'd0), alu_f_s[31], alu_cf_s, alu_of_s};
        end else begin
            result_r <= result_r;
        end
    end

    assign dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : rf_r[dbg_addr];
    assign result    = result_r;
    assign flags     = flags_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign req_ready = ready_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios plus randomized operations
// checked against a behavioural register-file/ALU model.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        ext_we;
    logic [4:0]  ext_waddr;
    logic [31:0] ext_wdata;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        done;
    logic        busy;
`ifdef ALU_IMM_EN
    logic        use_imm;
    logic [31:0] imm;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mrf [0:31];
    logic [3:0]  op_list [0:9];

    alu_exec_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .alu_op(alu_op),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
`ifdef ALU_IMM_EN
        .use_imm(use_imm), .imm(imm),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .result(result), .flags(flags),
        .done(done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU from arithmetic definitions: returns {ZF,SF,CF,OF,F}
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic cf;
        logic of;
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        f = 32'd0; cf = 1'b0; of = 1'b0; sr = 64'sd0;
        case (op)
            4'b0000: begin
                f = a + b; sr = sa + sb;
                cf = ({32'd0, a} + {32'd0, b}) != {32'd0, f};
                of = sr != longint'($signed(f));
            end
            4'b1000: begin
                f = a - b; sr = sa - sb;
                cf = a < b;
                of = sr != longint'($signed(f));
            end
            4'b0001: f = (b > 32'd31) ? 32'd0 : (a << b[4:0]);
            4'b0010: f = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: f = (a < b) ? 32'd1 : 32'd0;
            4'b0100: f = a ^ b;
            4'b0101: f = (b > 32'd31) ? 32'd0 : (a >> b[4:0]);
            4'b1101: f = (b > 32'd31) ? {32{a[31]}} : $unsigned($signed(a) >>> b[4:0]);
            4'b0110: f = a | b;
            4'b0111: f = a & b;
            default: f = 32'd0;
        endcase
        return {(f == 32'd0), f[31], cf, of, f};
    endfunction

    task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        @(posedge clk); #1;
        ext_we = 1'b0;
        if (a != 5'd0) mrf[a] = d;
        dbg_addr = a; #1;
        checks++;
        if (dbg_data !== mrf[a]) begin
            errors++;
            $display("FAIL ext_write x%0d: got %h want %h", a, dbg_data, mrf[a]);
        end
    endtask

    // One full operation starting at posedge+1 in IDLE; optional same-cycle ext write
    task automatic do_op(input string tag, input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] d, input logic ui, input logic [31:0] im,
                         input logic ew, input logic [4:0] ewa, input logic [31:0] ewd);
        logic [31:0] opa;
        logic [31:0] opb;
        logic [35:0] exp;
        if (ew && ewa != 5'd0) mrf[ewa] = ewd;
        opa = mrf[a1];
        opb = mrf[a2];
`ifdef ALU_IMM_EN
        if (ui) opb = im;
        use_imm = ui; imm = im;
`else
        if (ui && im == 32'hFFFF_FFFF) opb = mrf[a2];
`endif
        exp = ref_alu(op, opa, opb);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_idle: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; alu_op = op; rs1_addr = a1; rs2_addr = a2; rd_addr = d;
        ext_we = ew; ext_waddr = ewa; ext_wdata = ewd;
        @(posedge clk); #1;
        req_valid = 1'b0; ext_we = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s read_status: got busy=%b ready=%b done=%b want 1 0 0", tag, busy, req_ready, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s exec_done: got %b want 0", tag, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || result !== exp[31:0] || flags !== exp[35:32]) begin
            errors++;
            $display("FAIL %s wb: got done=%b result=%h flags=%b want 1 %h %b",
                     tag, done, result, flags, exp[31:0], exp[35:32]);
        end
        @(posedge clk); #1;
        if (d != 5'd0) mrf[d] = exp[31:0];
        dbg_addr = d; #1;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || dbg_data !== mrf[d]) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b ready=%b x%0d=%h want 0 1 %h",
                     tag, done, req_ready, d, dbg_data, mrf[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b result=%h flags=%b want 1 0 0 0 0000",
                     req_ready, busy, done, result, flags);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        dbg_addr = 5'd17; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf: got %h want 0", dbg_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        ext_write(5'd1, 32'd5);
        ext_write(5'd2, 32'd3);
        do_op("add", 4'b0000, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (result !== 32'd8 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL add_const: got %h %b want 00000008 0000", result, flags);
        end
        do_op("sub", 4'b1000, 5'd2, 5'd1, 5'd4, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (result !== 32'hFFFF_FFFE || flags !== 4'b0110) begin
            errors++;
            $display("FAIL sub_const: got %h %b want fffffffe 0110", result, flags);
        end
        do_op("xor_x0", 4'b0100, 5'd1, 5'd1, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (result !== 32'd0 || flags !== 4'b1000 || dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL xor_x0_const: got %h %b x0=%h want 0 1000 0", result, flags, dbg_data);
        end
        ext_write(5'd0, 32'hDEAD_BEEF);
    endtask

    task automatic test_ignore_when_busy();
        int dones;
        logic [31:0] exp8;
        dones = 0;
        exp8 = mrf[1] + mrf[2];
        req_valid = 1'b1; alu_op = 4'b0000; rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd8;
        @(posedge clk); #1;
        alu_op = 4'b0100; rd_addr = 5'd11;
        @(posedge clk); #1;
        ext_we = 1'b1; ext_waddr = 5'd5; ext_wdata = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; ext_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        mrf[8] = exp8;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d want 1", dones);
        end
        dbg_addr = 5'd5; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL busy_ext_ignored: got %h want 0", dbg_data);
        end
        dbg_addr = 5'd8; #1;
        checks++;
        if (dbg_data !== exp8) begin
            errors++;
            $display("FAIL busy_wb: got %h want %h", dbg_data, exp8);
        end
        dbg_addr = 5'd11; #1;
        checks++;
        if (dbg_data !== mrf[11]) begin
            errors++;
            $display("FAIL busy_req_ignored: got %h want %h", dbg_data, mrf[11]);
        end
        do_op("same_cycle_ext", 4'b0000, 5'd9, 5'd9, 5'd12, 1'b0, 32'd0, 1'b1, 5'd9, $urandom);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_first", 4'b0000, 5'd1, 5'd2, 5'd10, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_op("b2b_second", 4'b0000, 5'd10, 5'd10, 5'd13, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (result !== (mrf[1] + mrf[2]) * 32'd2) begin
            errors++;
            $display("FAIL b2b_hazard: got %h want %h", result, (mrf[1] + mrf[2]) * 32'd2);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        dones = 0;
        req_valid = 1'b1; alu_op = 4'b0000; rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got ready=%b busy=%b done=%b result=%h flags=%b want 1 0 0 0 0000",
                     req_ready, busy, done, result, flags);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        dbg_addr = 5'd6; #1;
        checks++;
        if (dones != 0 || dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst_no_wb: got dones=%0d x6=%h want 0 0", dones, dbg_data);
        end
    endtask

    task automatic test_imm();
`ifdef ALU_IMM_EN
        ext_write(5'd1, 32'd5);
        do_op("sll_imm", 4'b0001, 5'd1, 5'd2, 5'd7, 1'b1, 32'd4, 1'b0, 5'd0, 32'd0);
        checks++;
        if (result !== 32'h50 || dbg_data !== 32'h50) begin
            errors++;
            $display("FAIL sll_imm_const: got %h x7=%h want 50 50", result, dbg_data);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 1; i < 32; i++) begin
            v = $urandom;
            if (i < 8) v = $urandom_range(0, 40);
            ext_write(i[4:0], v);
        end
        for (int n = 0; n < 60; n++) begin
            do_op("random", op_list[$urandom_range(0, 9)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 40)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    initial begin
        op_list[0] = 4'b0000; op_list[1] = 4'b1000; op_list[2] = 4'b0001; op_list[3] = 4'b0010;
        op_list[4] = 4'b0011; op_list[5] = 4'b0100; op_list[6] = 4'b0101; op_list[7] = 4'b1101;
        op_list[8] = 4'b0110; op_list[9] = 4'b0111;
        rst = 1'b1; req_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
        alu_op = 4'd0; ext_we = 1'b0; ext_waddr = 5'd0; ext_wdata = 32'd0; dbg_addr = 5'd0;
`ifdef ALU_IMM_EN
        use_imm = 1'b0; imm = 32'd0;
`endif
        test_reset();
        test_directed();
        test_ignore_when_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_imm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
